// File: rtl/pavana_mem_slave_if.sv
// Request/acknowledge/response bundle between a PAVANA crossbar port and a memory slave.
interface pavana_mem_slave_if;
  logic        req_i;
  logic [31:0] addr_bi;
  logic        cmd_i;
  logic [31:0] wdata_bi;
  logic        ack_o;
  logic [31:0] rdata_bo;
  logic        resp_o;

  modport slave (
    input  req_i, addr_bi, cmd_i, wdata_bi,
    output ack_o, rdata_bo, resp_o
  );

  modport master (
    output req_i, addr_bi, cmd_i, wdata_bi,
    input  ack_o, rdata_bo, resp_o
  );
endinterface

// File: rtl/pavana_mem_slave.sv
// Word-addressed RAM slave: optional ack wait states, silent writes, and
// fixed-latency in-order read responses through a non-stalling valid/data pipeline.
module pavana_mem_slave #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned ACK_WAIT       = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pavana_mem_slave_if.slave       bus
);

  localparam int unsigned DEPTH      = 1 << MEM_ADDR_WIDTH;
  localparam logic [3:0]  ACK_WAIT_C = 4'(ACK_WAIT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic                      ack_s;
  logic                      wr_acc_s;
  logic                      rd_acc_s;
  logic [MEM_ADDR_WIDTH-1:0] word_s;
  logic                      unused_s;

  logic [31:0]               mem_q [DEPTH];
  logic [RD_LATENCY-1:0]     vld_q;
  logic [31:0]               dat_q [RD_LATENCY];

  assign word_s   = bus.addr_bi[MEM_ADDR_WIDTH+1:2];
  assign unused_s = ^{bus.addr_bi[31:MEM_ADDR_WIDTH+2], bus.addr_bi[1:0]};

  // Wait-state sequencing; ack never looks at address, command or data.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ack_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (ACK_WAIT_C == 4'd0) begin
            ack_s = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!bus.req_i) begin
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q == ACK_WAIT_C) begin
          ack_s   = 1'b1;
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Reset overrides acknowledgement in the same cycle, which also blocks writes.
  assign bus.ack_o = ack_s & ~rst_i;
  assign wr_acc_s  = bus.req_i & bus.ack_o & bus.cmd_i;
  assign rd_acc_s  = bus.req_i & bus.ack_o & ~bus.cmd_i;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Storage array: contents survive reset and are undefined until written.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_q[word_s] <= bus.wdata_bi;
    end
  end

  // Read pipeline: stage 0 captures the synchronous RAM read, later stages shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= 32'd0;
      end
    end else begin
      vld_q[0] <= rd_acc_s;
      dat_q[0] <= mem_q[word_s];
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.resp_o   = vld_q[RD_LATENCY-1];
  assign bus.rdata_bo = vld_q[RD_LATENCY-1] ? dat_q[RD_LATENCY-1] : 32'd0;

endmodule
